// File: rtl/clk_div_pkg.sv
// Shared types and helpers for the lock-qualified clock divider bank.
package clk_div_pkg;

  typedef enum logic [1:0] {
    StUnlocked,
    StSettle,
    StLocked
  } lock_state_t;

  // Per-channel counter behaviour for the coming edge, decoded from the lock FSM.
  typedef enum logic [1:0] {
    ChanHold,
    ChanAlign,
    ChanRun
  } chan_mode_t;

  function automatic int unsigned chan_width(int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Ratios below 2 cannot produce a square wave; they are treated as 2.
  function automatic int unsigned clamp_div(int unsigned d);
    return (d < 2) ? 32'd2 : d;
  endfunction

endpackage

// File: rtl/clk_div_chan.sv
// One divider channel: counter, active and shadow configuration, registered outputs.
module clk_div_chan
  import clk_div_pkg::*;
#(
  parameter int unsigned DivW       = 16,
  parameter int unsigned DefaultDiv = 2
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  chan_mode_t      mode_i,
  input  logic            locked_i,
  input  logic            wr_i,
  input  logic [DivW-1:0] wr_div_i,
  input  logic [DivW-1:0] wr_phase_i,
  output logic            pending_o,
  output logic            outclk_o,
  output logic            outclk_en_o
);

  localparam logic [DivW-1:0] One = DivW'(1);

  logic [DivW-1:0] cnt_q, cnt_d;
  logic [DivW-1:0] div_q, div_d;
  logic [DivW-1:0] phase_q, phase_d;
  logic [DivW-1:0] sh_div_q, sh_phase_q;
  logic [DivW-1:0] half_d;
  logic            pending_q, pending_d;
  logic            outclk_q, outclk_d;
  logic            en_q, en_d;
  logic            wrap;
  logic            apply;

  always_comb begin
    wrap      = (cnt_q == (div_q - One));
    // While locked, a new ratio only lands on a period boundary so no runt phase appears.
    apply     = pending_q && (!locked_i || ((mode_i == ChanRun) && wrap));
    div_d     = apply ? sh_div_q : div_q;
    phase_d   = apply ? sh_phase_q : phase_q;
    pending_d = wr_i || (pending_q && !apply);
    half_d    = (div_d >> 1) + DivW'(div_d[0]);

    unique case (mode_i)
      ChanAlign: cnt_d = (phase_d >= div_d) ? '0 : phase_d;
      ChanRun:   cnt_d = wrap ? '0 : (cnt_q + One);
      default:   cnt_d = '0;
    endcase

    outclk_d = (mode_i != ChanHold) && (cnt_d < half_d);
    en_d     = (mode_i != ChanHold) && (cnt_d == '0);
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      cnt_q      <= '0;
      div_q      <= DivW'(DefaultDiv);
      phase_q    <= '0;
      sh_div_q   <= DivW'(DefaultDiv);
      sh_phase_q <= '0;
      pending_q  <= 1'b0;
      outclk_q   <= 1'b0;
      en_q       <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      div_q     <= div_d;
      phase_q   <= phase_d;
      pending_q <= pending_d;
      outclk_q  <= outclk_d;
      en_q      <= en_d;
      if (wr_i) begin
        sh_div_q   <= DivW'(clamp_div(32'(wr_div_i)));
        sh_phase_q <= wr_phase_i;
      end
    end
  end

  assign pending_o   = pending_q;
  assign outclk_o    = outclk_q;
  assign outclk_en_o = en_q;

endmodule

// File: rtl/clk_div_bank.sv
// Lock-qualified bank of programmable clock dividers running on the PLL output clock.
module clk_div_bank
  import clk_div_pkg::*;
#(
  parameter int unsigned NUM_CLOCKS  = 4,
  parameter int unsigned DIV_W       = 16,
  parameter int unsigned LOCK_CYCLES = 1024,
  parameter int unsigned DEFAULT_DIV = 2,
  localparam int unsigned CHAN_W     = chan_width(NUM_CLOCKS)
) (
  input  logic                  refclk,
  input  logic                  rst,
  input  logic                  pll_locked,
  input  logic                  cfg_valid,
  output logic                  cfg_ready,
  input  logic [CHAN_W-1:0]     cfg_chan,
  input  logic [DIV_W-1:0]      cfg_div,
  input  logic [DIV_W-1:0]      cfg_phase,
  output logic [NUM_CLOCKS-1:0] outclk,
  output logic [NUM_CLOCKS-1:0] outclk_en,
  output logic                  locked
);

  localparam int unsigned SettleW = $clog2(LOCK_CYCLES);
  // The SETTLE entry edge already counts as one high cycle, hence the -2.
  localparam logic [SettleW-1:0] SettleLast = SettleW'(LOCK_CYCLES - 2);

  logic [1:0]            sync_q;
  logic                  sync;
  lock_state_t           state_q, state_d;
  logic [SettleW-1:0]    settle_q, settle_d;
  logic                  locked_q;
  chan_mode_t            mode;
  logic                  accept;
  logic [NUM_CLOCKS-1:0] wr;
  logic [NUM_CLOCKS-1:0] pending;

  assign sync = sync_q[1];

  always_comb begin
    state_d  = state_q;
    settle_d = settle_q;
    unique case (state_q)
      StUnlocked: begin
        if (sync) begin
          state_d  = StSettle;
          settle_d = '0;
        end
      end
      StSettle: begin
        if (!sync) begin
          state_d = StUnlocked;
        end else if (settle_q == SettleLast) begin
          state_d = StLocked;
        end else begin
          settle_d = settle_q + SettleW'(1);
        end
      end
      StLocked: begin
        if (!sync) state_d = StUnlocked;
      end
      default: state_d = StUnlocked;
    endcase
  end

  always_comb begin
    mode = ChanHold;
    if (state_d == StLocked) begin
      mode = (state_q == StLocked) ? ChanRun : ChanAlign;
    end
  end

  always_ff @(posedge refclk) begin
    if (!rst) begin
      sync_q   <= '0;
      state_q  <= StUnlocked;
      settle_q <= '0;
      locked_q <= 1'b0;
    end else begin
      sync_q   <= {sync_q[0], pll_locked};
      state_q  <= state_d;
      settle_q <= settle_d;
      locked_q <= (state_d == StLocked);
    end
  end

  // Only one shadow may be in flight, so the port stalls until it lands.
  assign cfg_ready = ~|pending;
  assign accept    = cfg_valid && cfg_ready;
  assign locked    = locked_q;

  for (genvar i = 0; i < NUM_CLOCKS; i++) begin : g_chan
    assign wr[i] = accept && (cfg_chan == CHAN_W'(i));

    clk_div_chan #(
      .DivW       (DIV_W),
      .DefaultDiv (DEFAULT_DIV)
    ) u_chan (
      .clk_i       (refclk),
      .rst_ni      (rst),
      .mode_i      (mode),
      .locked_i    (state_q == StLocked),
      .wr_i        (wr[i]),
      .wr_div_i    (cfg_div),
      .wr_phase_i  (cfg_phase),
      .pending_o   (pending[i]),
      .outclk_o    (outclk[i]),
      .outclk_en_o (outclk_en[i])
    );
  end

endmodule

// File: tb/tb_clk_div_bank.sv
// Directed scoreboard bench for clk_div_bank with three channels and an 8-cycle lock.
module tb_clk_div_bank;

  localparam int unsigned NCLK = 3;
  localparam int unsigned DW   = 16;
  localparam int unsigned LC   = 8;

  logic            refclk = 1'b0;
  logic            rst;
  logic            pll_locked;
  logic            cfg_valid;
  logic            cfg_ready;
  logic [1:0]      cfg_chan;
  logic [DW-1:0]   cfg_div;
  logic [DW-1:0]   cfg_phase;
  logic [NCLK-1:0] outclk;
  logic [NCLK-1:0] outclk_en;
  logic            locked;

  typedef struct {
    string      tag;
    int         sel;
    logic [7:0] val;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  always #5 refclk = ~refclk;

  clk_div_bank #(
    .NUM_CLOCKS  (NCLK),
    .DIV_W       (DW),
    .LOCK_CYCLES (LC),
    .DEFAULT_DIV (2)
  ) dut (
    .refclk     (refclk),
    .rst        (rst),
    .pll_locked (pll_locked),
    .cfg_valid  (cfg_valid),
    .cfg_ready  (cfg_ready),
    .cfg_chan   (cfg_chan),
    .cfg_div    (cfg_div),
    .cfg_phase  (cfg_phase),
    .outclk     (outclk),
    .outclk_en  (outclk_en),
    .locked     (locked)
  );

  // sel: 0 locked, 1 outclk, 2 outclk_en, 3 cfg_ready
  function automatic logic [7:0] observe(int sel);
    case (sel)
      0:       return {7'b0, locked};
      1:       return {5'b0, outclk};
      2:       return {5'b0, outclk_en};
      default: return {7'b0, cfg_ready};
    endcase
  endfunction

  // {en, clk} of a channel with ratio d and start count p, j cycles after the lock edge.
  function automatic logic [1:0] chan_bits(int d, int p, int j);
    int c;
    c = (p + j) % d;
    return {c == 0, c < (d + 1) / 2};
  endfunction

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic sb_push(input string tag, input int sel, input logic [7:0] val);
    exp_t e;
    e.tag = tag;
    e.sel = sel;
    e.val = val;
    sb.push_back(e);
  endtask

  task automatic tick();
    exp_t e;
    @(posedge refclk);
    #1;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      check(e.tag, observe(e.sel), e.val);
    end
  endtask

  task automatic run_check(input string tag, input int d0, input int p0, input int d1,
                           input int p1, input int d2, input int p2, input int j0, input int n);
    logic [1:0] b0, b1, b2;
    for (int j = j0; j < j0 + n; j++) begin
      b0 = chan_bits(d0, p0, j);
      b1 = chan_bits(d1, p1, j);
      b2 = chan_bits(d2, p2, j);
      sb_push(tag, 0, 8'd1);
      sb_push(tag, 1, {5'b0, b2[0], b1[0], b0[0]});
      sb_push(tag, 2, {5'b0, b2[1], b1[1], b0[1]});
      tick();
    end
  endtask

  // Edges 1..LC+1 after pll_locked rises must still read unlocked.
  task automatic lock_seq(input string tag);
    for (int t = 1; t <= LC + 1; t++) begin
      sb_push(tag, 0, 8'd0);
      sb_push(tag, 1, 8'd0);
      tick();
    end
  endtask

  task automatic cfg_write(input logic [1:0] chan, input int div, input int phase);
    check("cfg_write_ready", {7'b0, cfg_ready}, 8'd1);
    cfg_chan  = chan;
    cfg_div   = DW'(div);
    cfg_phase = DW'(phase);
    cfg_valid = 1'b1;
    tick();
    cfg_valid = 1'b0;
  endtask

  task automatic wait_ready(input string tag, input int bound);
    int t;
    t = 0;
    while (!cfg_ready && t < bound) begin
      tick();
      t++;
    end
    check(tag, {7'b0, cfg_ready}, 8'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst        = 1'b0;
    pll_locked = 1'b0;
    cfg_valid  = 1'b0;
    cfg_chan   = '0;
    cfg_div    = '0;
    cfg_phase  = '0;
    tick();
    tick();
    sb_push("rst_locked", 0, 8'd0);
    sb_push("rst_outclk", 1, 8'd0);
    sb_push("rst_en", 2, 8'd0);
    sb_push("rst_ready", 3, 8'd1);
    tick();
    rst = 1'b1;

    // Ratio 5 written while unlocked: applied on the next edge.
    cfg_chan  = 2'd1;
    cfg_div   = DW'(5);
    cfg_phase = '0;
    cfg_valid = 1'b1;
    sb_push("wr_unlocked_busy", 3, 8'd0);
    tick();
    cfg_valid = 1'b0;
    sb_push("wr_unlocked_done", 3, 8'd1);
    tick();

    pll_locked = 1'b1;
    lock_seq("lock_rise");
    run_check("d5_run", 2, 0, 5, 0, 2, 0, 0, 13);

    // Ch1 now at count 2 of 5; ratio 4 must wait for the wrap.
    cfg_chan  = 2'd1;
    cfg_div   = DW'(4);
    cfg_phase = '0;
    cfg_valid = 1'b1;
    sb_push("wrap_busy", 3, 8'd0);
    run_check("d5_tail", 2, 0, 5, 0, 2, 0, 13, 1);
    cfg_valid = 1'b0;
    sb_push("wrap_busy", 3, 8'd0);
    run_check("d5_tail", 2, 0, 5, 0, 2, 0, 14, 1);
    sb_push("wrap_done", 3, 8'd1);
    run_check("d4_run", 2, 0, 4, 1, 2, 0, 15, 8);

    cfg_write(2'd0, 6, 3);
    wait_ready("ch0_apply", 20);
    cfg_write(2'd1, 6, 0);
    wait_ready("ch1_apply", 20);

    // One-cycle lock drop: locked falls 3 edges later, relock 10 edges after re-rise.
    pll_locked = 1'b0;
    tick();
    pll_locked = 1'b1;
    sb_push("drop_hold", 0, 8'd1);
    tick();
    sb_push("drop_locked", 0, 8'd0);
    sb_push("drop_outclk", 1, 8'd0);
    sb_push("drop_en", 2, 8'd0);
    tick();
    for (int t = 0; t < 7; t++) begin
      sb_push("relock_wait", 0, 8'd0);
      sb_push("relock_outclk", 1, 8'd0);
      tick();
    end
    run_check("phase_run", 6, 3, 6, 0, 2, 0, 0, 12);

    // Glitch during SETTLE restarts the settle window.
    pll_locked = 1'b0;
    tick();
    tick();
    sb_push("glitch_pre", 0, 8'd0);
    tick();
    pll_locked = 1'b1;
    for (int t = 1; t <= 17; t++) begin
      if (t == 7) pll_locked = 1'b0;
      sb_push("glitch_settle", 0, 8'(t == 17));
      tick();
      if (t == 7) pll_locked = 1'b1;
    end

    // Ratio 0 behaves as 2.
    pll_locked = 1'b0;
    tick();
    tick();
    sb_push("d0_unlock", 0, 8'd0);
    tick();
    cfg_write(2'd1, 0, 0);
    sb_push("d0_applied", 3, 8'd1);
    tick();
    pll_locked = 1'b1;
    lock_seq("d0_lock");
    run_check("d0_as_d2", 6, 3, 2, 0, 2, 0, 0, 8);

    // Reset with a shadow pending on ch0.
    cfg_write(2'd0, 10, 0);
    check("rst_pending", {7'b0, cfg_ready}, 8'd0);
    rst = 1'b0;
    sb_push("rst2_locked", 0, 8'd0);
    sb_push("rst2_outclk", 1, 8'd0);
    sb_push("rst2_en", 2, 8'd0);
    sb_push("rst2_ready", 3, 8'd1);
    tick();
    rst = 1'b1;
    lock_seq("rst_relock");
    run_check("default_div", 2, 0, 2, 0, 2, 0, 0, 6);

    // Out-of-range channel: accepted, nothing changes.
    cfg_write(2'd3, 7, 0);
    check("oob_ready", {7'b0, cfg_ready}, 8'd1);
    run_check("oob_nochange", 2, 0, 2, 0, 2, 0, 7, 6);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
